// File: rtl/msdap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | msdap_pkg : shared constants and state encoding for the MSDAP      |
// |             convolution sequencer.                  Rev 1.0        |
// +--------------------------------------------------------------------+
package msdap_pkg;
  localparam int NUM_GROUPS     = 16;
  localparam int GRP_W          = 4;
  localparam int COEFF_AW       = 9;
  localparam int DATA_AW        = 9;
  localparam int K_W            = 8;
  localparam int WORD_W         = 16;
  localparam int COEFF_SIGN_BIT = 8;
  localparam int COEFF_K_MSB    = 7;
  localparam logic [DATA_AW-1:0] HIST_MAX = 9'd511;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RJ_RD   = 3'd1,
    S_RJ_WAIT = 3'd2,
    S_TERM    = 3'd3,
    S_DRAIN   = 3'd4,
    S_SHIFT   = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  function automatic logic [DATA_AW-1:0] hist_inc(input logic [DATA_AW-1:0] h);
    return (h == HIST_MAX) ? h : h + 1'b1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/msdap_conv_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | msdap_conv_sequencer_if : control, memory-read and accumulator     |
// |                           strobe bundle of the sequencer. Rev 1.0  |
// +--------------------------------------------------------------------+
interface msdap_conv_sequencer_if;
  logic                             start;
  logic                             clear;
  logic [msdap_pkg::DATA_AW-1:0]    x_ptr;
  logic [msdap_pkg::GRP_W-1:0]      rj_addr;
  logic [msdap_pkg::WORD_W-1:0]     rj_data;
  logic [msdap_pkg::COEFF_AW-1:0]   coeff_addr;
  logic [msdap_pkg::WORD_W-1:0]     coeff_data;
  logic [msdap_pkg::DATA_AW-1:0]    data_addr;
  logic                             acc_clr;
  logic                             acc_en;
  logic                             acc_sub;
  logic                             acc_shift;
  logic                             busy;
  logic                             done;
  logic                             overrun;

  modport slave (
    input  start, clear, x_ptr, rj_data, coeff_data,
    output rj_addr, coeff_addr, data_addr, acc_clr, acc_en, acc_sub,
           acc_shift, busy, done, overrun
  );

  modport master (
    output start, clear, x_ptr, rj_data, coeff_data,
    input  rj_addr, coeff_addr, data_addr, acc_clr, acc_en, acc_sub,
           acc_shift, busy, done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/msdap_term_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | msdap_term_pipe : coefficient -> data address / enable / sign      |
// |                   two-stage term pipeline.          Rev 1.0        |
// +--------------------------------------------------------------------+
module msdap_term_pipe
  import msdap_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                issue_i,
  input  logic [DATA_AW-1:0]  x_ptr_i,
  input  logic [DATA_AW-1:0]  hist_i,
  input  logic [WORD_W-1:0]   coeff_data_i,
  output logic [DATA_AW-1:0]  data_addr_o,
  output logic                acc_en_o,
  output logic                acc_sub_o
);
  logic [K_W-1:0]     k;
  logic               unused_coeff_bits;
  logic               issue_q;
  logic               s1_vld_q;
  logic               s1_en_q;
  logic               s1_sub_q;
  logic [DATA_AW-1:0] data_addr_q;
  logic               acc_en_q;
  logic               acc_sub_q;

  assign k                 = coeff_data_i[COEFF_K_MSB:0];
  assign unused_coeff_bits = ^coeff_data_i[WORD_W-1:COEFF_SIGN_BIT+1];

  // Samples older than the first one since reset/clear read as zero: never enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      issue_q     <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_sub_q    <= 1'b0;
      data_addr_q <= '0;
      acc_en_q    <= 1'b0;
      acc_sub_q   <= 1'b0;
    end else begin
      issue_q  <= issue_i;
      s1_vld_q <= issue_q;
      if (issue_q) begin
        data_addr_q <= x_ptr_i - DATA_AW'(k);
        s1_en_q     <= (DATA_AW'(k) <= hist_i);
        s1_sub_q    <= coeff_data_i[COEFF_SIGN_BIT];
      end
      acc_en_q  <= s1_vld_q & s1_en_q;
      acc_sub_q <= s1_vld_q & s1_en_q & s1_sub_q;
    end
  end

  assign data_addr_o = data_addr_q;
  assign acc_en_o    = acc_en_q;
  assign acc_sub_o   = acc_sub_q;
endmodule
`default_nettype wire

// File: rtl/msdap_conv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | msdap_conv_sequencer : walks the Rj groups per sample and drives   |
// |                        the shift-accumulate datapath.  Rev 1.0     |
// +--------------------------------------------------------------------+
module msdap_conv_sequencer
  import msdap_pkg::*;
(
  input  logic                    sClk,
  input  logic                    reset,
  msdap_conv_sequencer_if.slave   bus
);
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

  state_e              state_q;
  logic [GRP_W-1:0]    g_q;
  logic [WORD_W-1:0]   rem_q;
  logic [COEFF_AW-1:0] coeff_ptr_q;
  logic [DATA_AW-1:0]  x_ptr_q;
  logic [DATA_AW-1:0]  hist_q;
  logic                drain_q;
  logic                acc_shift_q;
  logic                done_q;
  logic                busy_q;
  logic [DATA_AW-1:0]  w_data_addr;
  logic                w_acc_en;
  logic                w_acc_sub;
  logic                w_start_ok;

  assign w_start_ok = bus.start & ~bus.clear & ~reset;

  always_ff @(posedge sClk) begin
    if (reset || bus.clear) begin
      state_q     <= S_IDLE;
      g_q         <= '0;
      rem_q       <= '0;
      coeff_ptr_q <= '0;
      x_ptr_q     <= '0;
      hist_q      <= '0;
      drain_q     <= 1'b0;
      acc_shift_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_shift_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            coeff_ptr_q <= '0;
            g_q         <= '0;
            x_ptr_q     <= bus.x_ptr;
            busy_q      <= 1'b1;
            state_q     <= S_RJ_RD;
          end
        end
        S_RJ_RD:   state_q <= S_RJ_WAIT;
        S_RJ_WAIT: begin
          rem_q   <= bus.rj_data;
          drain_q <= 1'b0;
          state_q <= (bus.rj_data == '0) ? S_DRAIN : S_TERM;
        end
        S_TERM: begin
          coeff_ptr_q <= coeff_ptr_q + 1'b1;
          rem_q       <= rem_q - 1'b1;
          if (rem_q == WORD_W'(1)) state_q <= S_DRAIN;
        end
        // Two drain cycles let the last term's acc_en land before the shift strobe.
        S_DRAIN: begin
          drain_q <= ~drain_q;
          if (drain_q) state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          acc_shift_q <= 1'b1;
          g_q         <= g_q + 1'b1;
          state_q     <= (g_q == LAST_GRP) ? S_DONE : S_RJ_RD;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          hist_q  <= hist_inc(hist_q);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  msdap_term_pipe u_term_pipe (
    .clk_i        (sClk),
    .rst_i        (reset),
    .flush_i      (bus.clear),
    .issue_i      (state_q == S_TERM),
    .x_ptr_i      (x_ptr_q),
    .hist_i       (hist_q),
    .coeff_data_i (bus.coeff_data),
    .data_addr_o  (w_data_addr),
    .acc_en_o     (w_acc_en),
    .acc_sub_o    (w_acc_sub)
  );

  assign bus.rj_addr    = g_q;
  assign bus.coeff_addr = coeff_ptr_q;
  assign bus.data_addr  = w_data_addr;
  assign bus.acc_en     = w_acc_en;
  assign bus.acc_sub    = w_acc_sub;
  assign bus.acc_shift  = acc_shift_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.acc_clr    = w_start_ok & (state_q == S_IDLE);
  assign bus.overrun    = w_start_ok & (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_msdap_conv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_msdap_conv_sequencer : directed bench with Rj/coeff memories.   |
// |                                                     Rev 1.0        |
// +--------------------------------------------------------------------+
module tb_msdap_conv_sequencer;
  logic sClk  = 1'b0;
  logic reset = 1'b1;
  always #5 sClk = ~sClk;

  msdap_conv_sequencer_if bus();

  msdap_conv_sequencer dut (
    .sClk  (sClk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] rj_mem    [16];
  logic [15:0] coeff_mem [512];

  always @(posedge sClk) begin
    bus.rj_data    <= rj_mem[bus.rj_addr];
    bus.coeff_data <= coeff_mem[bus.coeff_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int         lat, n_en, n_sub, n_shift, n_ovr, n_done, n_coll, n_clr, clr0, busy1;
  logic [8:0] first_addr, last_addr, prev_addr;
  logic [4:0] post_clr;
  logic [8:0] cseq [$];

  task automatic run(input logic [8:0] xp, input int extra_start, input int clear_at);
    lat = -1; n_en = 0; n_sub = 0; n_shift = 0; n_ovr = 0; n_done = 0;
    n_coll = 0; n_clr = 0; busy1 = 0; first_addr = '0; last_addr = '0;
    post_clr = 5'h1f;
    cseq.delete();
    @(posedge sClk); #1;
    bus.start = 1'b1;
    bus.x_ptr = xp;
    @(negedge sClk);
    clr0      = int'(bus.acc_clr);
    prev_addr = bus.data_addr;
    for (int c = 1; c <= 1500; c++) begin
      @(posedge sClk); #1;
      bus.start = (c == extra_start);
      bus.clear = (c == clear_at);
      @(negedge sClk);
      if (c == 1) begin
        busy1 = int'(bus.busy);
        cseq.push_back(bus.coeff_addr);
      end else if (bus.coeff_addr != cseq[$]) begin
        cseq.push_back(bus.coeff_addr);
      end
      if (bus.acc_en) begin
        n_en++;
        if (n_en == 1) first_addr = prev_addr;
        last_addr = prev_addr;
        if (bus.acc_sub) n_sub++;
      end
      if (bus.acc_shift) n_shift++;
      if (bus.overrun)   n_ovr++;
      if (bus.acc_clr)   n_clr++;
      if (bus.acc_en && (bus.acc_shift || bus.acc_clr)) n_coll++;
      if (clear_at > 0 && c == clear_at + 1)
        post_clr = {bus.acc_en, bus.acc_shift, bus.done, bus.busy, bus.acc_clr};
      if (bus.done) begin
        n_done++;
        if (lat < 0) lat = c;
      end
      prev_addr = bus.data_addr;
      if (clear_at < 0 && bus.done) break;
      if (clear_at > 0 && c >= clear_at + 150) break;
    end
    bus.start = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic set_rj_all(input logic [15:0] v);
    for (int i = 0; i < 16; i++) rj_mem[i] = v;
  endtask

  int errs;

  initial begin
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.x_ptr = '0;
    set_rj_all(16'd0);
    for (int i = 0; i < 512; i++) coeff_mem[i] = 16'h0000;

    repeat (3) @(posedge sClk);
    @(negedge sClk);
    check_val("reset_outputs",
      {bus.rj_addr, bus.coeff_addr, bus.data_addr, bus.acc_clr, bus.acc_en, bus.acc_sub,
       bus.acc_shift, bus.busy, bus.done, bus.overrun}, 64'd0);
    @(posedge sClk); #1;
    reset = 1'b0;
    @(negedge sClk);
    check_val("idle_outputs", {bus.acc_en, bus.acc_shift, bus.busy, bus.done}, 64'd0);

    // Rj all 1, k=0 coefficients, hist=0.
    set_rj_all(16'd1);
    run(9'd5, -1, -1);
    check_val("t1_latency", lat, 98);
    check_val("t1_acc_clr", clr0, 1);
    check_val("t1_busy", busy1, 1);
    check_val("t1_en_cnt", n_en, 16);
    check_val("t1_shift_cnt", n_shift, 16);
    check_val("t1_sub_cnt", n_sub, 0);
    check_val("t1_first_addr", first_addr, 5);
    check_val("t1_last_addr", last_addr, 5);
    check_val("t1_collisions", n_coll, 0);
    check_val("t1_done_cnt", n_done, 1);

    // Clear history, then grow it across three runs.
    @(posedge sClk); #1; bus.clear = 1'b1;
    @(posedge sClk); #1; bus.clear = 1'b0;
    set_rj_all(16'd0);
    rj_mem[0] = 16'd3;
    coeff_mem[0] = 16'h0000; coeff_mem[1] = 16'h0001; coeff_mem[2] = 16'h0002;
    run(9'd100, -1, -1);
    check_val("t2a_latency", lat, 85);
    check_val("t2a_en_cnt", n_en, 1);
    check_val("t2a_addr", first_addr, 100);
    check_val("t2a_shift_cnt", n_shift, 16);
    run(9'd100, -1, -1);
    check_val("t2b_en_cnt", n_en, 2);
    run(9'd100, -1, -1);
    check_val("t2c_en_cnt", n_en, 3);
    check_val("t2c_first_addr", first_addr, 100);
    check_val("t2c_last_addr", last_addr, 98);

    // Subtract term with data address wrap; upper coeff bits are junk.
    rj_mem[0] = 16'd1;
    coeff_mem[0] = 16'hAB03;
    run(9'd1, -1, -1);
    check_val("t3_latency", lat, 83);
    check_val("t3_en_cnt", n_en, 1);
    check_val("t3_sub_cnt", n_sub, 1);
    check_val("t3_wrap_addr", first_addr, 510);

    // Second start ten cycles into the run.
    set_rj_all(16'd1);
    for (int i = 0; i < 16; i++) coeff_mem[i] = 16'h0000;
    run(9'd7, 10, -1);
    check_val("t4_overrun_cnt", n_ovr, 1);
    check_val("t4_latency", lat, 98);
    check_val("t4_done_cnt", n_done, 1);
    check_val("t4_en_cnt", n_en, 16);
    check_val("t4_first_addr", first_addr, 7);

    // Clear in the middle of a long TERM phase.
    rj_mem[0] = 16'd40;
    run(9'd3, -1, 6);
    check_val("t5_post_clear", post_clr, 0);
    check_val("t5_done_cnt", n_done, 0);
    set_rj_all(16'd0);
    rj_mem[0] = 16'd3;
    coeff_mem[0] = 16'h0000; coeff_mem[1] = 16'h0001; coeff_mem[2] = 16'h0002;
    run(9'd20, -1, -1);
    check_val("t5_hist0_en_cnt", n_en, 1);
    check_val("t5_hist0_addr", first_addr, 20);

    // Rj sum of 520 wraps the coefficient pointer.
    set_rj_all(16'd0);
    rj_mem[0] = 16'd512;
    rj_mem[1] = 16'd8;
    for (int i = 0; i < 512; i++) coeff_mem[i] = 16'h0000;
    run(9'd0, -1, -1);
    check_val("t6_latency", lat, 602);
    check_val("t6_en_cnt", n_en, 520);
    check_val("t6_collisions", n_coll, 0);
    errs = 0;
    if (cseq.size() < 520) errs = 1000;
    else
      for (int i = 0; i < 520; i++)
        if (cseq[i] != 9'(i % 512)) errs++;
    check_val("t6_coeff_seq_errs", errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
